inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Inverse of the RV32I decode path: packs instruction fields (type, opcode, rd, rs1, rs2,
//  funct3, funct7, immediate) into a 32-bit instruction word. The immediate bit scatter is
//  the exact inverse of the TYPE_* immediate extraction in the decoder.
//  Serves the debug instruction injector and self-test program generator.
//  Valid/ready in, buffered valid/ready out; illegal requests emit a NOP and are flagged.
// PARAMETERS
//  XLEN        32  instruction/immediate width (only 32 supported)
//  FIFO_DEPTH  2   output buffer entries; power of 2, >= 2
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous; discards buffered words
//  in_valid   in   1     request valid
//  in_ready   out  1     request accepted when in_valid && in_ready
//  in_itype   in   3     `TYPE_R/I/S/B/U/J from defines.vh
//  in_opcode  in   7     major opcode (`OP, `LOAD, `JAL, ...)
//  in_rd      in   5     destination register (R/I/U/J)
//  in_rs1     in   5     source 1 (R/I/S/B)
//  in_rs2     in   5     source 2 (R/S/B)
//  in_funct3  in   3     funct3 (R/I/S/B)
//  in_funct7  in   7     funct7 (R only)
//  in_imm     in   XLEN  immediate, value as the decoder would produce it (sign-extended)
//  out_valid  out  1     out_inst/out_err hold the FIFO head
//  out_ready  in   1     consumer pops head when out_valid && out_ready
//  out_inst   out  32    encoded instruction
//  out_err    out  1     head entry was illegal; out_inst = 32'h0000_0013
//  enc_count  out  16    words accepted since reset; wraps
//  err_count  out  16    illegal words accepted since reset; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO empty; counters 0.
//   - out_valid=0, out_inst=0, out_err=0, in_ready=1.
//  Encoding (combinational, registered on acceptance):
//   - R: {f7,rs2,rs1,f3,rd,op}
//   - I: {imm[11:0],rs1,f3,rd,op}
//   - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   - U: {imm[31:12],rd,op}
//   - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   - Fields not used by the type are ignored.
//  Illegal request (any of the following):
//   - in_itype not one of the six TYPE_* codes.
//   - in_opcode maps to a different type (LUI/AUIPC=U, JAL=J, BRANCH=B, STORE=S, OP=R,
//     LOAD/OP_IMM/JALR/MISC_MEM/SYSTEM=I), or is not one of those opcodes.
//   - I/S: imm[31:11] not all equal.
//   - B: imm[31:12] not all equal, or imm[0]=1.
//   - J: imm[31:20] not all equal, or imm[0]=1.
//   - U: imm[11:0]!=0.
//   - Result: entry {32'h0000_0013, err=1}; err_count += 1 (saturating).
//  Handshake and FIFO:
//   - in_ready = !full (registered state only; no combinational path from out_ready).
//   - Accepted request written at the accepting edge; out_valid rises the next cycle
//     (latency 1 when empty).
//   - FIFO order preserved; out_* stable while out_valid && !out_ready.
//   - Simultaneous push+pop: count unchanged; when full no push occurs even if popping.
//   - Empty: out_valid=0; out_inst/out_err hold their last values (don't care).
//   - enc_count increments on every acceptance, legal or not.
//   - flush: count->0, out_valid=0 next cycle; no push that cycle; counters kept.
//   - Reset mid-stream: all buffered words lost; no partial output.
// TESTING
//  I type, OP_IMM, rd=1, rs1=0, f3=0, imm=5 -> out_inst 0x00500093, out_err=0, one cycle later.
//  S type, STORE, rs1=1, rs2=2, f3=3'b010, imm=8 -> out_inst 0x0020A423.
//  B type, BRANCH, rs1=rs2=0, f3=0, imm=32'hFFFFFFFC -> out_inst 0xFE000EE3.
//  J type, JAL, rd=1, imm=32'h800 -> out_inst 0x001000EF.
//  I type, imm=2048 -> out_inst 0x00000013, out_err=1, err_count=1, enc_count=1.
//  out_ready=0, 3 back-to-back requests -> in_ready=0 after 2; drain returns 2 in order, then the 3rd.
//  rst_n pulsed low mid-drain -> out_valid=0 immediately, counters 0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields back into a 32-bit word behind a small
// output FIFO. Illegal field combinations are replaced by a NOP and flagged.
package inst_encoder_pkg;
  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } itype_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_itype,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic            out_err,
  output logic [15:0]     enc_count,
  output logic [15:0]     err_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } entry_t;

  // ---------------- combinational encode + legality ----------------
  itype_e      op_type;
  logic        op_known;
  logic        type_known;
  logic        imm_ok;
  logic        illegal;
  logic [31:0] raw_inst;
  entry_t      enc_entry;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_type  = TYPE_I;
    op_known = 1'b1;
    case (in_opcode)
      OPC_LUI, OPC_AUIPC: op_type = TYPE_U;
      OPC_JAL:            op_type = TYPE_J;
      OPC_BRANCH:         op_type = TYPE_B;
      OPC_STORE:          op_type = TYPE_S;
      OPC_OP:             op_type = TYPE_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: op_type = TYPE_I;
      default:            op_known = 1'b0;
    endcase
  end

  always_comb begin
    raw_inst   = INST_NOP;
    type_known = 1'b1;
    imm_ok     = 1'b0;
    // Immediate must be a sign-extension of exactly the bits the format can carry.
    case (in_itype)
      TYPE_R: begin
        raw_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        imm_ok   = 1'b1;
      end
      TYPE_I: begin
        raw_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        imm_ok   = (&in_imm[31:11]) || !(|in_imm[31:11]);
      end
      TYPE_S: begin
        raw_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        imm_ok   = (&in_imm[31:11]) || !(|in_imm[31:11]);
      end
      TYPE_B: begin
        raw_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        imm_ok   = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
      end
      TYPE_U: begin
        raw_inst = {in_imm[31:12], in_rd, in_opcode};
        imm_ok   = !(|in_imm[11:0]);
      end
      TYPE_J: begin
        raw_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        imm_ok   = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
      end
      default: type_known = 1'b0;
    endcase
  end

  assign illegal        = !type_known || !op_known || (in_itype != op_type) || !imm_ok;
  assign enc_entry.inst = illegal ? INST_NOP : raw_inst;
  assign enc_entry.err  = illegal;

  // ---------------- output FIFO ----------------
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               push;
  logic               pop;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_inst  = mem[rd_ptr].inst;
  assign out_err   = mem[rd_ptr].err;

  // NOTE: the storage is reset on purpose so out_inst/out_err read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample together.
      mem[wr_ptr] <= enc_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (push) begin
      enc_count <= enc_count + 16'd1;
      if (illegal && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: table of hand-encoded vectors plus backpressure,
// flush and mid-drain reset sequences.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_itype;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  always #5 clk = ~clk;

  inst_encoder #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_itype(in_itype), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  typedef struct {
    logic [2:0]  itype;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.itype = t; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_itype = v.itype; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_enc;
    int exp_errc;
    vec_t va, vb, vc;

    // Illegal 2048 first so the counters read 1/1 right after it.
    vecs[0]  = mk(3'(TYPE_I), OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h0000_0013, 1'b1);
    vecs[1]  = mk(3'(TYPE_I), OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h0050_0093, 1'b0);
    vecs[2]  = mk(3'(TYPE_S), OPC_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020_A423, 1'b0);
    vecs[3]  = mk(3'(TYPE_B), OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    vecs[4]  = mk(3'(TYPE_J), OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    vecs[5]  = mk(3'(TYPE_R), OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,       32'h4020_81B3, 1'b0);
    vecs[6]  = mk(3'(TYPE_U), OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[7]  = mk(3'(TYPE_I), OPC_OP_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0113, 1'b0);
    vecs[8]  = mk(3'(TYPE_J), OPC_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
    vecs[9]  = mk(3'(TYPE_I), OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    vecs[10] = mk(3'(TYPE_S), OPC_STORE,  5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8,      32'h0020_A423, 1'b0);
    vecs[11] = mk(3'(TYPE_B), OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'h8000_0063, 1'b0);
    vecs[12] = mk(3'd6,       OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h0000_0013, 1'b1);
    vecs[13] = mk(3'(TYPE_R), OPC_OP_IMM, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h0000_0013, 1'b1);
    vecs[14] = mk(3'(TYPE_B), OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h0000_0013, 1'b1);
    vecs[15] = mk(3'(TYPE_U), OPC_AUIPC,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_0013, 1'b1);
    vecs[16] = mk(3'(TYPE_J), OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[1]);
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_inst",  out_inst,       32'd0);
    check("reset out_err",   32'(out_err),   32'd0);
    check("reset enc_count", 32'(enc_count), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Table: one word in, checked one cycle later, popped on the following edge.
    exp_enc = 0; exp_errc = 0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_enc++;
      if (vecs[i].exp_err) exp_errc++;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_inst", i),  out_inst,       vecs[i].exp_inst);
      check($sformatf("vec%0d out_err", i),   32'(out_err),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d enc_count", i), 32'(enc_count), 32'(exp_enc));
      check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(exp_errc));
    end
    @(negedge clk);
    check("drained out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three back-to-back requests with the consumer stalled.
    va = vecs[1]; vb = vecs[2]; vc = vecs[5];
    out_ready = 1'b0;
    drive(va); in_valid = 1'b1;
    @(negedge clk) drive(vb);
    @(negedge clk) drive(vc);
    check("bp full in_ready",  32'(in_ready), 32'd0);
    check("bp head inst",      out_inst,      va.exp_inst);
    @(negedge clk);
    check("bp stall in_ready", 32'(in_ready), 32'd0);
    check("bp stall stable",   out_inst,      va.exp_inst);
    check("bp enc_count",      32'(enc_count), 32'(exp_enc + 2));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp 2nd inst",       out_inst,      vb.exp_inst);
    check("bp pop in_ready",   32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp 3rd inst",       out_inst,      vc.exp_inst);
    check("bp 3rd valid",      32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp empty",          32'(out_valid), 32'd0);
    check("bp enc_count end",  32'(enc_count), 32'(exp_enc + 3));
    exp_enc += 3;

    // Flush discards buffered words but keeps the counters.
    out_ready = 1'b0;
    drive(va); in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp_enc += 2;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready",  32'(in_ready),  32'd1);
    check("flush enc_count", 32'(enc_count), 32'(exp_enc));
    check("flush err_count", 32'(err_count), 32'(exp_errc));

    // Reset pulsed mid-drain.
    drive(va); in_valid = 1'b1;
    @(negedge clk) drive(vb);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("pre-reset out_inst", out_inst, vb.exp_inst);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset enc_count", 32'(enc_count), 32'd0);
    check("mid reset err_count", 32'(err_count), 32'd0);
    check("mid reset in_ready",  32'(in_ready),  32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post reset out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
